// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 program ROM loader.
//   loader_state_t : loader FSM states (also exported on the state_dbg port)
//   WE_CNT_W       : width of the prog_we pulse counter (WE_LEN up to 15)
//   HOLD_CNT_W     : width of the post-load reset hold counter (RST_HOLD up to 255)
//   CSUM_W         : checksum width
package jtdsp16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_t;

  localparam int WE_CNT_W   = 4;
  localparam int HOLD_CNT_W = 8;
  localparam int CSUM_W     = 16;

endpackage

// File: rtl/jtdsp16_loader_csum.sv
// Image checksum for the ROM loader: a 16-bit running sum (mod 2^16) of every
// image byte plus a compare against the two-byte trailer (low byte first).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cen         : clock enable
//   clr         : clear the accumulator (new download)
//   add_en      : add byte_in to the accumulator (image byte accepted)
//   ref_lo_en   : capture byte_in as the low byte of the reference
//   byte_in     : host byte
//   match       : sum equals {byte_in, captured low byte}; valid while the
//                 high trailer byte is presented
module jtdsp16_loader_csum
  import jtdsp16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       clr,
  input  logic       add_en,
  input  logic       ref_lo_en,
  input  logic [7:0] byte_in,
  output logic       match
);

  logic [CSUM_W-1:0] sum;
  logic [7:0]        ref_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum    <= '0;
      ref_lo <= '0;
    end else if (cen) begin
      if (clr)
        sum <= '0;
      else if (add_en)
        sum <= sum + CSUM_W'(byte_in);
      if (ref_lo_en)
        ref_lo <= byte_in;
    end
  end

  // Compared against the live high byte so the decision lands on the
  // same edge that accepts the last trailer byte.
  assign match = (sum == {byte_in, ref_lo});

endmodule

// File: rtl/jtdsp16_rom_loader.sv
// Downloads the DSP16 program ROM from a host byte stream, holding the DSP in
// reset during the download and releasing it RST_HOLD cen cycles afterwards.
// Optional checksum trailer: define JTDSP16_LOADER_CSUM_EN.
// Handshake: a host byte moves when dl_valid & dl_ready & cen are all high at
// a rising clk edge; dl_valid may be held across cycles, dl_ready only rises
// in LOAD/CSUM and is masked by abort so an aborted byte is never taken.
// Ports:
//   clk, rst_n, cen       : clock, async active-low reset, clock enable
//   start, abort          : begin / cancel a download (abort has priority)
//   dl_valid/dl_data/dl_ready : host byte stream
//   prog_addr/prog_data/prog_we : ROM programming interface
//   dsp_rst               : DSP core reset, active high
//   busy, done, err       : status
//   state_dbg             : current FSM state
module jtdsp16_rom_loader
  import jtdsp16_pkg::*;
#(
  parameter int ROM_AW    = 13,
  parameter int ROM_BYTES = 8192,
  parameter int WE_LEN    = 2,
  parameter int RST_HOLD  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              start,
  input  logic              abort,
  input  logic              dl_valid,
  input  logic [7:0]        dl_data,
  output logic              dl_ready,
  output logic [ROM_AW-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic              prog_we,
  output logic              dsp_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output loader_state_t     state_dbg
);

  localparam logic [ROM_AW-1:0]     LAST_ADDR = ROM_AW'(ROM_BYTES - 1);
  localparam logic [WE_CNT_W-1:0]   WE_LAST   = WE_CNT_W'(WE_LEN - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

  loader_state_t         state, state_nxt;
  logic [ROM_AW-1:0]     addr, addr_nxt;
  logic [7:0]            data, data_nxt;
  logic                  we, we_nxt;
  logic [WE_CNT_W-1:0]   we_cnt, we_cnt_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic                  is_busy;
  logic                  xfer;

`ifdef JTDSP16_LOADER_CSUM_EN
  logic csum_hi, csum_hi_nxt;
  logic csum_clr, csum_add, csum_ref_lo, csum_match;

  jtdsp16_loader_csum u_csum (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .clr       (csum_clr),
    .add_en    (csum_add),
    .ref_lo_en (csum_ref_lo),
    .byte_in   (dl_data),
    .match     (csum_match)
  );
`endif

  assign is_busy  = (state == ST_LOAD) || (state == ST_WRITE) ||
                    (state == ST_CSUM) || (state == ST_HOLD);
  assign dl_ready = ((state == ST_LOAD) || (state == ST_CSUM)) && !abort;
  assign xfer     = dl_valid && dl_ready && cen;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    data_nxt     = data;
    we_nxt       = we;
    we_cnt_nxt   = we_cnt;
    hold_cnt_nxt = hold_cnt;
`ifdef JTDSP16_LOADER_CSUM_EN
    csum_hi_nxt  = csum_hi;
    csum_clr     = 1'b0;
    csum_add     = 1'b0;
    csum_ref_lo  = 1'b0;
`endif
    if (cen) begin
      if (abort) begin
        // abort outranks start everywhere; it only changes state when busy
        if (is_busy) begin
          state_nxt = ST_IDLE;
          we_nxt    = 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
              state_nxt   = ST_LOAD;
              addr_nxt    = '0;
`ifdef JTDSP16_LOADER_CSUM_EN
              csum_clr    = 1'b1;
              csum_hi_nxt = 1'b0;
`endif
            end
          end
          ST_LOAD: begin
            if (xfer) begin
              data_nxt   = dl_data;
              we_nxt     = 1'b1;
              we_cnt_nxt = '0;
              state_nxt  = ST_WRITE;
`ifdef JTDSP16_LOADER_CSUM_EN
              csum_add   = 1'b1;
`endif
            end
          end
          ST_WRITE: begin
            if (we_cnt == WE_LAST) begin
              we_nxt = 1'b0;
              if (addr == LAST_ADDR) begin
                // address stays at the last byte: no wrap inside an image
                hold_cnt_nxt = '0;
`ifdef JTDSP16_LOADER_CSUM_EN
                state_nxt    = ST_CSUM;
`else
                state_nxt    = ST_HOLD;
`endif
              end else begin
                addr_nxt  = addr + ROM_AW'(1);
                state_nxt = ST_LOAD;
              end
            end else begin
              we_cnt_nxt = we_cnt + WE_CNT_W'(1);
            end
          end
`ifdef JTDSP16_LOADER_CSUM_EN
          ST_CSUM: begin
            if (xfer) begin
              if (!csum_hi) begin
                csum_ref_lo = 1'b1;
                csum_hi_nxt = 1'b1;
              end else begin
                state_nxt = csum_match ? ST_HOLD : ST_ERR;
              end
            end
          end
`endif
          ST_HOLD: begin
            if (hold_cnt == HOLD_LAST)
              state_nxt = ST_DONE;
            else
              hold_cnt_nxt = hold_cnt + HOLD_CNT_W'(1);
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      data     <= '0;
      we       <= 1'b0;
      we_cnt   <= '0;
      hold_cnt <= '0;
`ifdef JTDSP16_LOADER_CSUM_EN
      csum_hi  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      data     <= data_nxt;
      we       <= we_nxt;
      we_cnt   <= we_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
`ifdef JTDSP16_LOADER_CSUM_EN
      csum_hi  <= csum_hi_nxt;
`endif
    end
  end

  assign prog_addr = addr;
  assign prog_data = data;
  assign prog_we   = we;
  assign busy      = is_busy;
  assign done      = (state == ST_DONE);
  // A start accepted in DONE puts the core back in reset in that same cycle.
  assign dsp_rst   = (state != ST_DONE) || (start && cen && !abort);
  assign state_dbg = state;
`ifdef JTDSP16_LOADER_CSUM_EN
  assign err       = (state == ST_ERR);
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Bench for jtdsp16_rom_loader with a 16-byte image. Build with
// JTDSP16_LOADER_CSUM_EN defined to exercise the checksum trailer.
module tb_jtdsp16_rom_loader;
  import jtdsp16_pkg::*;

  localparam int ROM_AW    = 4;
  localparam int ROM_BYTES = 16;
  localparam int WE_LEN    = 3;
  localparam int RST_HOLD  = 6;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              cen = 1;
  logic              start = 0;
  logic              abort = 0;
  logic              dl_valid = 0;
  logic [7:0]        dl_data = 0;
  logic              dl_ready;
  logic [ROM_AW-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              prog_we;
  logic              dsp_rst;
  logic              busy;
  logic              done;
  logic              err;
  loader_state_t     state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];   // {addr, data} of each expected ROM write
  logic [7:0]  img[16];
  int          we_run = 0;
  int          hold_run = 0;
  logic        trunc_ok = 0;
  logic        cen_div = 0;
  int          gap_max = 0;

  jtdsp16_rom_loader #(
    .ROM_AW(ROM_AW), .ROM_BYTES(ROM_BYTES), .WE_LEN(WE_LEN), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .abort(abort),
    .dl_valid(dl_valid), .dl_data(dl_data), .dl_ready(dl_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .dsp_rst(dsp_rst), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cen ----------------
  always #5 clk = ~clk;

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      if (cen_div) begin
        ph  = (ph == 2) ? 0 : ph + 1;
        cen = (ph == 0);
      end else begin
        cen = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_we) begin
        if (cen) begin
          if (we_run == 0) begin
            if (exp_q.size() == 0)
              check("we_unexpected", 32'd1, 32'd0);
            else
              check("we_addr_data", {20'd0, prog_addr, prog_data}, {20'd0, exp_q.pop_front()});
          end
          we_run++;
        end
      end else if (we_run != 0) begin
        if (!trunc_ok) check("we_len", we_run, WE_LEN);
        trunc_ok = 0;
        we_run = 0;
      end
      // HOLD is the only busy state with neither prog_we nor dl_ready
      if (!busy) begin
        if (done && hold_run != 0) check("hold_len", hold_run, RST_HOLD);
        hold_run = 0;
      end else if (cen && !prog_we && !dl_ready && !abort) begin
        hold_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic [3:0] a, input logic is_img);
    int n = 0;
    logic got = 0;
    if (is_img) exp_q.push_back({a, b});
    dl_valid = 1; dl_data = b;
    while (!got && n < 400) begin
      @(negedge clk);
      got = dl_valid && dl_ready && cen;
      n++;
    end
    if (!got) check("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (gap_max > 0) begin
      dl_valid = 0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pulse_ctl(input logic is_abort);
    int n = 0;
    if (is_abort) abort = 1; else start = 1;
    do begin @(negedge clk); n++; end while (!cen && n < 20);
    @(posedge clk); #1;
    abort = 0; start = 0;
  endtask

  task automatic send_image(input logic [7:0] trailer_adj);
    logic [15:0] sum;
    sum = 16'(trailer_adj);
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], 4'(i), 1'b1);
      sum = sum + 16'(img[i]);
    end
`ifdef JTDSP16_LOADER_CSUM_EN
    send_byte(sum[7:0], 4'd0, 1'b0);
    send_byte(sum[15:8], 4'd0, 1'b0);
`endif
    dl_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done || err) && n < 3000) begin @(negedge clk); n++; end
    if (!(done || err)) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dsp_rst", dsp_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dl_ready", dl_ready, 0);
    check("rst_prog_we", prog_we, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // full load, data == address, dl_valid held high
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    pulse_ctl(1'b0);
    check("load_busy", busy, 1);
    check("load_dsp_rst", dsp_rst, 1);
    send_image(8'd0);
    wait_done();
    @(negedge clk);
    check("full_done", done, 1);
    check("full_dsp_rst", dsp_rst, 0);
    check("full_err", err, 0);
    check("full_q_empty", exp_q.size(), 0);

    // start in DONE: reset goes up in the start cycle itself
    start = 1;
    @(negedge clk);
    check("restart_rst_same_cycle", dsp_rst, 1);
    @(posedge clk); #1;
    start = 0;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);

    // second image: random bytes, cen 1-of-3, random valid gaps, start while busy
    cen_div = 1;
    gap_max = 4;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) send_byte(img[i], 4'(i), 1'b1);
    pulse_ctl(1'b0);
    check("start_ignored_busy", busy, 1);
    for (int i = 8; i < 16; i++) send_byte(img[i], 4'(i), 1'b1);
    begin
      logic [15:0] s = 0;
      for (int i = 0; i < 16; i++) s = s + 16'(img[i]);
`ifdef JTDSP16_LOADER_CSUM_EN
      send_byte(s[7:0], 4'd0, 1'b0);
      send_byte(s[15:8], 4'd0, 1'b0);
`endif
    end
    dl_valid = 0;
    wait_done();
    @(negedge clk);
    check("rand_done", done, 1);
    check("rand_dsp_rst", dsp_rst, 0);
    check("rand_q_empty", exp_q.size(), 0);
    cen_div = 0;
    gap_max = 0;
    repeat (3) @(posedge clk);
    #1;

    // abort during the write of byte 5
    for (int i = 0; i < 16; i++) img[i] = 8'(8'hA0 + i);
    pulse_ctl(1'b0);
    for (int i = 0; i < 6; i++) send_byte(img[i], 4'(i), 1'b1);
    dl_valid = 0;
    check("pre_abort_we", prog_we, 1);
    trunc_ok = 1;
    pulse_ctl(1'b1);
    check("abort_prog_we", prog_we, 0);
    check("abort_busy", busy, 0);
    check("abort_dsp_rst", dsp_rst, 1);
    check("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_ignores_valid", dl_ready, 0);
    pulse_ctl(1'b0);
    check("restart_addr0", prog_addr, 0);
    send_image(8'd0);
    wait_done();
    @(negedge clk);
    check("after_abort_done", done, 1);
    check("after_abort_q_empty", exp_q.size(), 0);

`ifdef JTDSP16_LOADER_CSUM_EN
    // checksum: 0x00..0x0F sums to 0x0078; trailer 0x79 must fail
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    @(posedge clk); #1;
    pulse_ctl(1'b0);
    send_image(8'd1);
    wait_done();
    @(negedge clk);
    check("csum_err", err, 1);
    check("csum_err_dsp_rst", dsp_rst, 1);
    check("csum_err_done", done, 0);
    check("csum_err_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("csum_err_sticky", err, 1);
    pulse_ctl(1'b0);
    check("csum_err_cleared", err, 0);
    check("csum_err_restart_busy", busy, 1);
    pulse_ctl(1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
